// File: rtl/matrix_merge_64_col_if.sv
// Slice-in / matrix-out bundle for the 64x10 column merger.
// The slave side is the merger; the master side feeds slices and reads the result.
interface matrix_merge_64_col_if #(
  parameter int DATA_W     = 16,
  parameter int SLICE_ROWS = 16,
  parameter int COLS       = 10,
  parameter int NUM_SLICES = 4,
  parameter int SLICE_W    = SLICE_ROWS * COLS * DATA_W,
  parameter int MAT_W      = NUM_SLICES * SLICE_W,
  parameter int CNT_W      = $clog2(NUM_SLICES)
);
  logic                      start;
  logic signed [SLICE_W-1:0] slice_in;
  logic                      slice_valid;
  logic                      slice_ready;
  logic signed [MAT_W-1:0]   Matrix;
  logic [CNT_W-1:0]          slice_cnt;
  logic                      busy;
  logic                      finish;

  modport master (
    output start, slice_in, slice_valid,
    input  slice_ready, Matrix, slice_cnt, busy, finish
  );

  modport slave (
    input  start, slice_in, slice_valid,
    output slice_ready, Matrix, slice_cnt, busy, finish
  );
endinterface

// File: rtl/matrix_merge_64_col.sv
// Reassembles four 16x10 slices into one 64x10 matrix.
// Slice 0 lands in the MSB row group, slice 3 in the LSB row group.
module matrix_merge_64_col #(
  parameter int DATA_W     = 16,
  parameter int SLICE_ROWS = 16,
  parameter int COLS       = 10,
  parameter int NUM_SLICES = 4,
  parameter int SLICE_W    = SLICE_ROWS * COLS * DATA_W,
  parameter int MAT_W      = NUM_SLICES * SLICE_W,
  parameter int CNT_W      = $clog2(NUM_SLICES)
) (
  input  logic clk,
  input  logic rst,
  matrix_merge_64_col_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fin_q;
  logic [SLICE_W-1:0] grp_q [NUM_SLICES];

  logic hs;
  logic last;

  assign hs   = bus.slice_valid && (state_q == COLLECT);
  assign last = (cnt_q == CNT_W'(NUM_SLICES - 1));

  assign bus.slice_ready = (state_q == COLLECT);
  assign bus.busy        = (state_q == COLLECT);
  assign bus.slice_cnt   = cnt_q;
  assign bus.finish      = fin_q;

  // Row group k of the output is slice k, MSB first.
  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_place
    assign bus.Matrix[MAT_W-1-k*SLICE_W -: SLICE_W] = grp_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      for (int k = 0; k < NUM_SLICES; k++) begin
        grp_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
          end
        end
        COLLECT: begin
          if (hs) begin
            grp_q[cnt_q] <= bus.slice_in;
            cnt_q        <= cnt_q + 1'b1;
            if (last) begin
              state_q <= DONE;
              fin_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_merge_64_col.sv
// Directed bench for matrix_merge_64_col with a row-group model.
// A negedge process compares every output against the model each cycle.
module tb_matrix_merge_64_col;
  localparam int SW = 2560;
  localparam int MW = 4 * SW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_merge_64_col_if bus ();

  matrix_merge_64_col dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [SW-1:0] m_grp [4];
  int  m_cnt   = 0;
  int  m_phase = 0;
  logic m_fin  = 1'b0;
  logic m_live = 1'b0;

  function automatic logic [SW-1:0] pat(input logic [7:0] b);
    return {320{b}};
  endfunction

  function automatic logic [MW-1:0] m_mat();
    return {m_grp[0], m_grp[1], m_grp[2], m_grp[3]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_grp(input string nm, input int g,
                         input logic [SW-1:0] exp);
    logic [SW-1:0] act;
    act = bus.Matrix[MW-1-g*SW -: SW];
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s grp%0d got_lo=%h exp_lo=%h", nm, g,
               act[63:0], exp[63:0]);
    end
  endtask

  // Spec-level model: phase 0 idle, 1 collecting, 2 done.
  always @(posedge clk) begin
    m_live = 1'b1;
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_fin   = 1'b0;
      for (int g = 0; g < 4; g++) m_grp[g] = '0;
    end else if (m_phase == 1) begin
      if (bus.slice_valid) begin
        m_grp[m_cnt] = bus.slice_in;
        m_cnt = (m_cnt + 1) % 4;
        if (m_cnt == 0) begin
          m_phase = 2;
          m_fin   = 1'b1;
        end
      end
    end else if (bus.start) begin
      m_phase = 1;
      m_cnt   = 0;
      m_fin   = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [MW-1:0] em;
      em = m_mat();
      checks++;
      if (bus.Matrix !== em) begin
        errors++;
        $display("FAIL cyc_matrix got_lo=%h exp_lo=%h",
                 bus.Matrix[63:0], em[63:0]);
      end
      chk("cyc_finish", 64'(bus.finish), 64'(m_fin));
      chk("cyc_busy", 64'(bus.busy), 64'(m_phase == 1));
      chk("cyc_ready", 64'(bus.slice_ready), 64'(m_phase == 1));
      chk("cyc_cnt", 64'(bus.slice_cnt), 64'(m_cnt));
    end
  end

  task automatic drive(input logic s, input logic v,
                       input logic [SW-1:0] d);
    bus.start       = s;
    bus.slice_valid = v;
    bus.slice_in    = d;
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] ones, zer, p5a, sev, dead;
  logic [SW-1:0] s_a, s_b, s_c, s_d, r_a, r_b;

  initial begin
    ones = '1;
    zer  = '0;
    p5a  = pat(8'h5A);
    sev  = SW'(7);
    dead = pat(8'hDE);
    s_a  = pat(8'h11);
    s_b  = pat(8'h22);
    s_c  = pat(8'h33);
    s_d  = pat(8'h44);
    r_a  = pat(8'hA1);
    r_b  = pat(8'hB2);

    rst = 1'b1;
    bus.start = 1'b0;
    bus.slice_valid = 1'b1;
    bus.slice_in = {80{$urandom()}};
    @(posedge clk);
    #1;
    bus.slice_in = {80{$urandom()}};
    drive(1'b1, 1'b1, bus.slice_in);
    chk("rst_matrix_nz", 64'(bus.Matrix != '0), 64'd0);
    chk("rst_finish", 64'(bus.finish), 64'd0);
    chk("rst_ready", 64'(bus.slice_ready), 64'd0);
    chk("rst_cnt", 64'(bus.slice_cnt), 64'd0);
    rst = 1'b0;

    // Valid in IDLE is ignored.
    drive(1'b0, 1'b1, dead);
    chk("idle_ign_cnt", 64'(bus.slice_cnt), 64'd0);
    chk("idle_ign_mat", 64'(bus.Matrix != '0), 64'd0);

    // Basic merge, back-to-back.
    drive(1'b1, 1'b0, zer);
    chk("bas_busy0", 64'(bus.busy), 64'd1);
    drive(1'b0, 1'b1, ones);
    drive(1'b0, 1'b1, zer);
    drive(1'b0, 1'b1, p5a);
    chk("bas_fin_early", 64'(bus.finish), 64'd0);
    chk("bas_cnt3", 64'(bus.slice_cnt), 64'd3);
    drive(1'b0, 1'b1, sev);
    chk("bas_finish", 64'(bus.finish), 64'd1);
    chk("bas_busy", 64'(bus.busy), 64'd0);
    chk("bas_cnt", 64'(bus.slice_cnt), 64'd0);
    chk_grp("bas", 0, ones);
    chk_grp("bas", 1, zer);
    chk_grp("bas", 2, p5a);
    chk_grp("bas", 3, sev);

    // Valid in DONE is ignored.
    drive(1'b0, 1'b1, dead);
    drive(1'b0, 1'b1, dead);
    chk_grp("done_ign", 0, ones);
    chk_grp("done_ign", 3, sev);
    chk("done_fin", 64'(bus.finish), 64'd1);

    // start+valid together: transition only.
    drive(1'b1, 1'b1, dead);
    chk("sv_cnt", 64'(bus.slice_cnt), 64'd0);
    chk("sv_fin", 64'(bus.finish), 64'd0);
    chk_grp("sv_keep", 0, ones);

    // Stall pattern 1,0,0,1,0,1,1 with start pulses in the gaps.
    drive(1'b0, 1'b1, s_a);
    chk("stl_c1", 64'(bus.slice_cnt), 64'd1);
    drive(1'b1, 1'b0, dead);
    drive(1'b0, 1'b0, dead);
    chk("stl_hold", 64'(bus.slice_cnt), 64'd1);
    drive(1'b0, 1'b1, s_b);
    chk("stl_c2", 64'(bus.slice_cnt), 64'd2);
    drive(1'b1, 1'b0, dead);
    drive(1'b0, 1'b1, s_c);
    chk("stl_c3", 64'(bus.slice_cnt), 64'd3);
    drive(1'b0, 1'b1, s_d);
    chk("stl_fin", 64'(bus.finish), 64'd1);
    chk_grp("stl", 0, s_a);
    chk_grp("stl", 1, s_b);
    chk_grp("stl", 2, s_c);
    chk_grp("stl", 3, s_d);

    // Partial re-run keeps the lower groups.
    drive(1'b1, 1'b0, zer);
    drive(1'b0, 1'b1, r_a);
    drive(1'b0, 1'b1, r_b);
    drive(1'b0, 1'b0, zer);
    chk("rr_fin", 64'(bus.finish), 64'd0);
    chk_grp("rr", 0, r_a);
    chk_grp("rr", 1, r_b);
    chk_grp("rr", 2, s_c);
    chk_grp("rr", 3, s_d);

    // Reset mid-collection, with a handshake in flight.
    rst = 1'b1;
    drive(1'b0, 1'b1, dead);
    rst = 1'b0;
    chk("mr_mat_nz", 64'(bus.Matrix != '0), 64'd0);
    chk("mr_busy", 64'(bus.busy), 64'd0);
    drive(1'b1, 1'b0, zer);
    drive(1'b0, 1'b1, s_d);
    drive(1'b0, 1'b1, s_c);
    drive(1'b0, 1'b1, s_b);
    drive(1'b0, 1'b1, s_a);
    chk("mr_fin", 64'(bus.finish), 64'd1);
    chk_grp("mr", 0, s_d);
    chk_grp("mr", 1, s_c);
    chk_grp("mr", 2, s_b);
    chk_grp("mr", 3, s_a);

    drive(1'b0, 1'b0, zer);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
